// File: rtl/sfi5_patgen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sfi5_patgen_pkg : shared types, PRBS constants and parallel LFSR stepping
// | Revision 1.0
// +-----------------------------------------------------------------------------
package sfi5_patgen_pkg;

  typedef enum logic [1:0] {
    PAT_FIXED  = 2'd0,
    PAT_CNT    = 2'd1,
    PAT_PRBS7  = 2'd2,
    PAT_PRBS31 = 2'd3
  } pat_mode_e;

  typedef enum logic {
    ERR_IDLE  = 1'b0,
    ERR_ARMED = 1'b1
  } err_state_e;

  localparam int unsigned PRBS7_LEN  = 7;
  localparam int unsigned PRBS7_TAP  = 6;
  localparam int unsigned PRBS31_LEN = 31;
  localparam int unsigned PRBS31_TAP = 28;
  localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
  localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;
  localparam int unsigned PRBS_MAX_W = 64;

  typedef struct packed {
    logic [PRBS_MAX_W-1:0] word;
    logic [30:0]           state;
  } prbs_step_t;

  // state[len-1] is the earliest pending bit; word fills MSB-first over width steps
  function automatic prbs_step_t prbs_next_word(input logic [30:0] state, input int unsigned width,
                                                input int unsigned len, input int unsigned tap);
    prbs_step_t  r;
    logic [30:0] st;
    logic [30:0] mask;
    logic [4:0]  msb;
    logic [4:0]  tb;
    logic        fb;
    msb    = 5'(len - 1);
    tb     = 5'(tap - 1);
    mask   = 31'h7FFF_FFFF >> (31 - len);
    st     = state & mask;
    r.word = '0;
    for (int unsigned i = 0; i < PRBS_MAX_W; i++) begin
      if (i < width) begin
        fb     = st[msb] ^ st[tb];
        r.word = {r.word[PRBS_MAX_W-2:0], st[msb]};
        st     = ((st << 1) | {30'd0, fb}) & mask;
      end
    end
    r.state = st;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfi5_pattern_core.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sfi5_pattern_core : mode latch plus counter/PRBS word source (DATA_W <= 64)
// | Revision 1.0
// +-----------------------------------------------------------------------------
module sfi5_pattern_core
  import sfi5_patgen_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              restart_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] fixed_i,
  output logic [DATA_W-1:0] word_o
);

  logic              init_q;
  pat_mode_e         mode_q;
  pat_mode_e         mode_cur;
  logic [DATA_W-1:0] cnt_q;
  logic [30:0]       lfsr_q;
  logic [30:0]       lfsr_d;
  prbs_step_t        step7;
  prbs_step_t        step31;

  // The first clock after reset release behaves like a restart for mode sampling
  assign mode_cur = init_q ? pat_mode_e'(mode_i) : mode_q;
  assign step7    = prbs_next_word(lfsr_q, DATA_W, PRBS7_LEN, PRBS7_TAP);
  assign step31   = prbs_next_word(lfsr_q, DATA_W, PRBS31_LEN, PRBS31_TAP);

  generate
    if (DATA_W < PRBS_MAX_W) begin : g_unused_word
      logic unused_word;
      assign unused_word = ^{step7.word[PRBS_MAX_W-1:DATA_W], step31.word[PRBS_MAX_W-1:DATA_W]};
    end
  endgenerate

  always_comb begin
    word_o = '0;
    lfsr_d = lfsr_q;
    case (mode_cur)
      PAT_FIXED: word_o = fixed_i;
      PAT_CNT:   word_o = cnt_q;
      PAT_PRBS7: begin
        word_o = step7.word[DATA_W-1:0];
        lfsr_d = step7.state;
      end
      default: begin
        word_o = step31.word[DATA_W-1:0];
        lfsr_d = step31.state;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_q <= 1'b1;
      mode_q <= PAT_FIXED;
      cnt_q  <= '0;
      lfsr_q <= PRBS31_SEED;
    end else begin
      init_q <= 1'b0;
      if (init_q) mode_q <= mode_cur;
      if (restart_i) begin
        mode_q <= pat_mode_e'(mode_i);
        cnt_q  <= '0;
        lfsr_q <= (pat_mode_e'(mode_i) == PAT_PRBS7) ? {24'd0, PRBS7_SEED} : PRBS31_SEED;
      end else if (enable_i) begin
        cnt_q  <= cnt_q + DATA_W'(1);
        lfsr_q <= lfsr_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfi5_skewed_pattern_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sfi5_skewed_pattern_gen : shared pattern source, per-lane skew taps and
// | optional single-bit error injection (SFI5_PATGEN_ERR_INJ_EN). Revision 1.0
// +-----------------------------------------------------------------------------
module sfi5_skewed_pattern_gen
  import sfi5_patgen_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  NUM_CH   = 16,
  parameter int  MAX_SKEW = 7,
  localparam int SKEW_W   = $clog2(MAX_SKEW + 1),
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic                     i_ENABLE,
  input  logic                     i_RESTART,
  input  logic [1:0]               iv_MODE,
  input  logic [DATA_W-1:0]        iv_FIXED,
  input  logic [NUM_CH*SKEW_W-1:0] iv_SKEW,
  input  logic                     i_INSERT_ERROR,
  input  logic [CH_W-1:0]          iv_ERR_CH,
  output logic                     o_ERR_ACK,
  output logic [NUM_CH*DATA_W-1:0] ov_DATA,
  output logic                     o_VALID
);

  localparam int PW = $clog2(MAX_SKEW + 2);

  logic [DATA_W-1:0]                gen_word;
  logic [MAX_SKEW-1:0][DATA_W-1:0]  hist_q;
  logic [MAX_SKEW:0][DATA_W-1:0]    view;
  logic [PW-1:0]                    prime_q;
  logic [NUM_CH-1:0]                flip;
  logic                             load;

  sfi5_pattern_core #(.DATA_W(DATA_W)) u_core (
    .clk_i     (i_CLK),
    .rst_ni    (i_RST_N),
    .enable_i  (i_ENABLE),
    .restart_i (i_RESTART),
    .mode_i    (iv_MODE),
    .fixed_i   (iv_FIXED),
    .word_o    (gen_word)
  );

  assign load = i_ENABLE && !i_RESTART;
  // Lanes tap the post-shift history so a skew-0 lane shows the word generated this edge
  assign view = {hist_q, gen_word};

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      hist_q  <= '0;
      prime_q <= '0;
    end else if (i_RESTART) begin
      hist_q  <= '0;
      prime_q <= '0;
    end else if (i_ENABLE) begin
      hist_q <= view[MAX_SKEW-1:0];
      if (prime_q != PW'(MAX_SKEW + 1)) prime_q <= prime_q + PW'(1);
    end
  end

  assign o_VALID = (prime_q == PW'(MAX_SKEW + 1));

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic [SKEW_W-1:0] skew_raw;
      logic [SKEW_W-1:0] skew;
      logic [DATA_W-1:0] data_q;
      assign skew_raw = iv_SKEW[c*SKEW_W +: SKEW_W];
      assign skew     = (skew_raw > SKEW_W'(MAX_SKEW)) ? SKEW_W'(MAX_SKEW) : skew_raw;
      always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N)  data_q <= '0;
        else if (load) data_q <= view[skew] ^ {{(DATA_W-1){1'b0}}, flip[c]};
      end
      assign ov_DATA[c*DATA_W +: DATA_W] = data_q;
    end
  endgenerate

`ifdef SFI5_PATGEN_ERR_INJ_EN
  err_state_e      state_q, state_d;
  logic [CH_W-1:0] err_ch_q, err_ch_d;
  logic            ack_q, ack_d;

  always_comb begin
    state_d  = state_q;
    err_ch_d = err_ch_q;
    ack_d    = 1'b0;
    flip     = '0;
    if (i_RESTART) begin
      state_d = ERR_IDLE;
    end else begin
      case (state_q)
        ERR_IDLE: if (i_INSERT_ERROR) begin
          state_d  = ERR_ARMED;
          err_ch_d = iv_ERR_CH;
        end
        ERR_ARMED: if (i_ENABLE) begin
          state_d = ERR_IDLE;
          ack_d   = 1'b1;
          // Out-of-range lane numbers match nothing but still acknowledge
          for (int c = 0; c < NUM_CH; c++) flip[c] = (err_ch_q == CH_W'(c));
        end
        default: state_d = ERR_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ERR_IDLE;
      err_ch_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_ch_q <= err_ch_d;
      ack_q    <= ack_d;
    end
  end

  assign o_ERR_ACK = ack_q;
`else
  logic unused_err;
  assign unused_err = ^{i_INSERT_ERROR, iv_ERR_CH};
  assign flip       = '0;
  assign o_ERR_ACK  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sfi5_skewed_pattern_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_sfi5_skewed_pattern_gen : randomized bench with a word-list reference model
// | Revision 1.0
// +-----------------------------------------------------------------------------
module tb_sfi5_skewed_pattern_gen;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 5;
  localparam int MAX_SKEW = 7;
  localparam int SKEW_W   = 3;
  localparam int CH_W     = 3;
`ifdef SFI5_PATGEN_ERR_INJ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     en = 1'b0;
  logic                     restart = 1'b0;
  logic                     ins = 1'b0;
  logic [1:0]               mode = 2'd1;
  logic [DATA_W-1:0]        fixed = '0;
  logic [NUM_CH*SKEW_W-1:0] skew = '0;
  logic [CH_W-1:0]          errch = '0;
  logic                     ack;
  logic                     valid;
  logic [NUM_CH*DATA_W-1:0] data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sfi5_skewed_pattern_gen #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_SKEW(MAX_SKEW)) dut (
    .i_CLK          (clk),
    .i_RST_N        (rst_n),
    .i_ENABLE       (en),
    .i_RESTART      (restart),
    .iv_MODE        (mode),
    .iv_FIXED       (fixed),
    .iv_SKEW        (skew),
    .i_INSERT_ERROR (ins),
    .iv_ERR_CH      (errch),
    .o_ERR_ACK      (ack),
    .ov_DATA        (data),
    .o_VALID        (valid)
  );

  // Reference model: list of words produced since restart, newest first
  logic [DATA_W-1:0]        m_data [NUM_CH];
  logic [DATA_W-1:0]        m_hist [$];
  bit                       m_bits [$];
  bit                       m_valid, m_ack, m_armed, m_init;
  int                       m_n, m_mode;
  logic [CH_W-1:0]          m_ch;
  bit                       s_en, s_rs, s_ins;
  logic [1:0]               s_mode;
  logic [DATA_W-1:0]        s_fix;
  logic [NUM_CH*SKEW_W-1:0] s_sk;
  logic [CH_W-1:0]          s_ch;
  logic [NUM_CH*DATA_W-1:0] ev;

  function automatic void m_seed(int md);
    m_bits.delete();
    for (int i = 0; i < ((md == 2) ? 7 : 31); i++) m_bits.push_back(1'b1);
  endfunction

  // b[m] = b[m-len] ^ b[m-tap]; m_bits holds the last len bits, oldest at index 0
  function automatic logic [DATA_W-1:0] m_prbs_word(int len, int tap);
    logic [DATA_W-1:0] w;
    bit nb;
    w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      nb = m_bits[0] ^ m_bits[len - tap];
      w  = {w[DATA_W-2:0], m_bits[0]};
      m_bits.push_back(nb);
      void'(m_bits.pop_front());
    end
    return w;
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < NUM_CH; c++) m_data[c] = '0;
    m_valid = 0; m_ack = 0; m_armed = 0; m_init = 1; m_n = 0; m_mode = 0;
    m_hist.delete();
  endfunction

  function automatic void m_step();
    logic [DATA_W-1:0] w;
    int s;
    if (m_init) begin
      m_init = 0; m_mode = int'(s_mode); m_seed(m_mode);
    end
    m_ack = 0;
    if (s_rs) begin
      m_mode = int'(s_mode); m_seed(m_mode);
      m_n = 0; m_hist.delete(); m_armed = 0; m_valid = 0;
      return;
    end
    if (s_en) begin
      case (m_mode)
        0:       w = s_fix;
        1:       w = DATA_W'(m_n);
        2:       w = m_prbs_word(7, 6);
        default: w = m_prbs_word(31, 28);
      endcase
      m_hist.push_front(w);
      if (m_hist.size() > MAX_SKEW + 1) void'(m_hist.pop_back());
      m_n++;
      for (int c = 0; c < NUM_CH; c++) begin
        s = int'(s_sk[c*SKEW_W +: SKEW_W]);
        if (s > MAX_SKEW) s = MAX_SKEW;
        m_data[c] = (s < m_hist.size()) ? m_hist[s] : '0;
        if (m_armed && int'(m_ch) == c) m_data[c][0] = ~m_data[c][0];
      end
      if (m_armed) begin
        m_armed = 0; m_ack = 1;
      end else if (s_ins && ERR_EN) begin
        m_armed = 1; m_ch = s_ch;
      end
    end else if (s_ins && ERR_EN && !m_armed) begin
      m_armed = 1; m_ch = s_ch;
    end
    m_valid = (m_n >= MAX_SKEW + 1);
  endfunction

  always @(posedge clk) begin
    s_en = en; s_rs = restart; s_ins = ins; s_mode = mode;
    s_fix = fixed; s_sk = skew; s_ch = errch;
    if (!rst_n) m_reset();
    else m_step();
    #1;
    for (int c = 0; c < NUM_CH; c++) ev[c*DATA_W +: DATA_W] = m_data[c];
    total++;
    if (data !== ev || valid !== m_valid || ack !== m_ack) begin
      bad++;
      $display("FAIL cycle_check t=%0t got data=%h valid=%b ack=%b expected data=%h valid=%b ack=%b",
               $time, data, valid, ack, ev, m_valid, m_ack);
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DATA_W-1:0] lane(int c);
    return data[c*DATA_W +: DATA_W];
  endfunction

  logic [DATA_W-1:0] pw [20];
  bit                pb [320];
  bit                ok;
  int                acks;

  initial begin
    skew = {3'd2, 3'd7, 3'd3, 3'd1, 3'd0};
    repeat (3) tick();
    check("reset_data", data, 0);
    check("reset_valid", valid, 0);
    check("reset_ack", ack, 0);

    // Counter mode priming and skew taps
    rst_n = 1; en = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("valid_before_prime", valid, 0);
      if (i == 8) check("valid_primed", valid, 1);
    end
    check("cnt_lane0", lane(0), 9);
    check("cnt_lane1", lane(1), 8);
    check("cnt_lane2", lane(2), 6);
    check("cnt_lane3", lane(3), 2);

    for (int i = 0; i < 8; i++) begin
      en = (i[0] == 1'b0);
      tick();
    end
    check("toggle_no_skip", lane(0), 13);

    // Restart beats enable and insert
    en = 1; restart = 1; ins = 1; errch = 0;
    tick();
    restart = 0; ins = 0;
    check("restart_valid", valid, 0);
    check("restart_holds_data", lane(0), 13);
    tick();
    check("restart_word0", lane(0), 0);
    check("restart_no_ack", ack, 0);

    // PRBS7 first word and 127-bit period
    mode = 2; restart = 1;
    tick();
    restart = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pw[i] = lane(0);
    end
    check("prbs7_first", pw[0], 16'hFE04);
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 16; j++) pb[i*16 + j] = pw[i][15 - j];
    ok = 1;
    for (int j = 0; j < 320 - 127; j++) if (pb[j] != pb[j + 127]) ok = 0;
    check("prbs7_period127", ok, 1);

    // Fixed pattern with error injection on lane 2
    mode = 0; fixed = 16'hA5A5; restart = 1;
    tick();
    restart = 0;
    repeat (9) tick();
    ins = 1; errch = 2;
    tick();
    check("arm_no_ack", ack, 0);
    tick();
    ins = 0;
    check("err_lane2", lane(2), ERR_EN ? 16'hA5A4 : 16'hA5A5);
    check("err_lane1_clean", lane(1), 16'hA5A5);
    check("err_ack", ack, ERR_EN);
    acks = 0;
    repeat (4) begin
      tick();
      acks += int'(ack);
    end
    check("single_ack", acks, 0);
    check("lane2_restored", lane(2), 16'hA5A5);

    ins = 1; errch = 6;
    tick();
    ins = 0;
    tick();
    check("oor_ack", ack, ERR_EN);
    check("oor_no_corrupt", data, {NUM_CH{16'hA5A5}});

    // Asynchronous reset while ARMED
    ins = 1; errch = 1;
    tick();
    ins = 0; en = 0;
    tick();
    #1 rst_n = 0;
    #1;
    check("async_reset_data", data, 0);
    check("async_reset_ack", ack, 0);
    tick();
    rst_n = 1; en = 1;
    tick();
    check("reset_cancels_arm_ack", ack, 0);
    check("reset_cancels_arm_lane1", lane(1), 0);
    check("post_reset_lane0", lane(0), 16'hA5A5);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 9) < 7);
      restart = ($urandom_range(0, 99) < 2);
      mode    = 2'($urandom_range(0, 3));
      ins     = en && ($urandom_range(0, 9) == 0);
      errch   = 3'($urandom_range(0, 7));
      fixed   = 16'($urandom);
      if ($urandom_range(0, 49) == 0) skew = 15'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
